// File: rtl/ifmap_bram_write_ctrl.sv
// rtl/ifmap_bram_write_ctrl.sv - stream-to-Ifmap-BRAM sequential write controller
//
// Purpose:
//   Takes a valid/ready data stream and writes it word by word into one selected
//   Ifmap BRAM bank over an inclusive address window [wr_addr_start, wr_addr_end].
//   Each accepted beat becomes a registered write exactly one cycle later.
//   Completion is reported to the TransConv control FSM with a one-cycle wr_done pulse.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   start               begin a window (only looked at while idle)
//   wr_addr_start/end   first / last (inclusive) write address of the window
//   bram_sel_in         target bank index
//   s_data/s_valid      input stream, s_ready is the handshake back-pressure
//   if_we               per-bank write enable, one-hot or zero
//   if_addr_wr_flat     per-bank write address, bank j at [j*ADDR_WIDTH +: ADDR_WIDTH]
//   if_din              write data shared by all banks
//   bram_sel_out        bank index latched at start
//   busy                window in progress
//   wr_done             one-cycle pulse after the final write
//   cfg_err             one-cycle pulse when a start is rejected

module ifmap_bram_write_ctrl #(
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           wr_addr_start,
    input  logic [ADDR_WIDTH-1:0]           wr_addr_end,
    input  logic [SEL_WIDTH-1:0]            bram_sel_in,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [NUM_BRAMS-1:0]            if_we,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0] if_addr_wr_flat,
    output logic [DATA_WIDTH-1:0]           if_din,
    output logic [SEL_WIDTH-1:0]            bram_sel_out,
    output logic                            busy,
    output logic                            wr_done,
    output logic                            cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_end_addr;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [NUM_BRAMS-1:0]  r_we;
    logic [ADDR_WIDTH-1:0] r_lane [NUM_BRAMS];
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_wr_done;
    logic                  r_cfg_err;

    logic w_accept;
    logic w_last;
    logic w_cfg_ok;

    // The handshake completes combinationally in WRITE so a beat can be taken every cycle.
    assign w_accept = s_valid && (r_state == S_WRITE);
    // Equality (not >=) so a window ending at the top address never needs a wrap.
    assign w_last   = (r_cur_addr == r_end_addr);
    // Bank index compared at 32 bits so a wider SEL_WIDTH can name a non-existent bank.
    assign w_cfg_ok = (wr_addr_start <= wr_addr_end) &&
                      ({{(32-SEL_WIDTH){1'b0}}, bram_sel_in} < 32'(NUM_BRAMS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur_addr <= '0;
            r_end_addr <= '0;
            r_sel      <= '0;
            r_we       <= '0;
            r_din      <= '0;
            r_wr_done  <= 1'b0;
            r_cfg_err  <= 1'b0;
            for (int j = 0; j < NUM_BRAMS; j++) begin
                r_lane[j] <= '0;
            end
        end else begin
            r_wr_done <= 1'b0;
            r_cfg_err <= 1'b0;

            // Only the selected lane moves; the others keep their last address across windows.
            for (int j = 0; j < NUM_BRAMS; j++) begin
                r_we[j] <= w_accept && (r_sel == SEL_WIDTH'(j));
                if (w_accept && (r_sel == SEL_WIDTH'(j))) begin
                    r_lane[j] <= r_cur_addr;
                end
            end
            if (w_accept) begin
                r_din <= s_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_cur_addr <= wr_addr_start;
                            r_end_addr <= wr_addr_end;
                            r_sel      <= bram_sel_in;
                            r_state    <= S_WRITE;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cur_addr <= r_cur_addr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // The final write is on the bus this cycle; completion is flagged one cycle on.
                    r_wr_done <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BRAMS; g++) begin : g_lane
            assign if_addr_wr_flat[g*ADDR_WIDTH +: ADDR_WIDTH] = r_lane[g];
        end
    endgenerate

    assign s_ready      = (r_state == S_WRITE);
    assign busy         = (r_state != S_IDLE);
    assign if_we        = r_we;
    assign if_din       = r_din;
    assign bram_sel_out = r_sel;
    assign wr_done      = r_wr_done;
    assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_ifmap_bram_write_ctrl.sv
// tb/tb_ifmap_bram_write_ctrl.sv - directed self-checking bench for ifmap_bram_write_ctrl

module tb_ifmap_bram_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  wr_addr_start;
    logic [8:0]  wr_addr_end;
    logic [3:0]  bram_sel_in;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] if_we;
    logic [143:0] if_addr_wr_flat;
    logic [15:0] if_din;
    logic [3:0]  bram_sel_out;
    logic        busy;
    logic        wr_done;
    logic        cfg_err;

    // Second instance with a 5-bit select so an out-of-range bank can be requested.
    logic        start5;
    logic [4:0]  sel5;
    logic        s_valid5;
    logic        s_ready5;
    logic [15:0] if_we5;
    logic [143:0] flat5;
    logic [15:0] din5;
    logic [4:0]  sel_out5;
    logic        busy5;
    logic        wr_done5;
    logic        cfg_err5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifmap_bram_write_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .wr_addr_start(wr_addr_start), .wr_addr_end(wr_addr_end),
        .bram_sel_in(bram_sel_in), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .if_we(if_we), .if_addr_wr_flat(if_addr_wr_flat),
        .if_din(if_din), .bram_sel_out(bram_sel_out), .busy(busy),
        .wr_done(wr_done), .cfg_err(cfg_err)
    );

    ifmap_bram_write_ctrl #(.SEL_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5),
        .wr_addr_start(wr_addr_start), .wr_addr_end(wr_addr_end),
        .bram_sel_in(sel5), .s_data(s_data), .s_valid(s_valid5),
        .s_ready(s_ready5), .if_we(if_we5), .if_addr_wr_flat(flat5),
        .if_din(din5), .bram_sel_out(sel_out5), .busy(busy5),
        .wr_done(wr_done5), .cfg_err(cfg_err5)
    );

    function automatic logic [8:0] lane_of(input int j);
        return if_addr_wr_flat[j*9 +: 9];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one window on dut with a per-cycle valid pattern; the model tracks the
    // expected address, data and hold values. glitch_k pulses start mid-window.
    task automatic run_window(input logic [3:0] sel, input logic [8:0] a, input logic [8:0] e,
                              input logic [15:0] vpat, input int glitch_k);
        int          remaining;
        int          k;
        logic [8:0]  exp_addr;
        logic [8:0]  last_addr;
        logic [15:0] last_din;
        logic [15:0] d;
        logic [15:0] exp_we;
        bit          have_prev;
        bit          acc;
        remaining = int'(e) - int'(a) + 1;
        exp_addr  = a;
        last_addr = '0;
        last_din  = '0;
        have_prev = 0;
        exp_we    = 16'(1) << sel;
        bram_sel_in   = sel;
        wr_addr_start = a;
        wr_addr_end   = e;
        s_valid       = 1'b0;
        start         = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || bram_sel_out !== sel || if_we !== 16'h0) begin
            n_fail++;
            $display("FAIL window_start sel=%0d: busy=%b s_ready=%b sel_out=%0d we=%h, required 1 1 %0d 0000",
                     sel, busy, s_ready, bram_sel_out, if_we, sel);
        end
        k = 0;
        while (remaining > 0 && k < 64) begin
            acc = vpat[k % 16];
            d   = 16'(32'hC000 + k*37 + int'(a) + int'(sel)*256);
            s_valid = acc;
            s_data  = d;
            if (k == glitch_k) begin
                start         = 1'b1;
                bram_sel_in   = 4'd1;
                wr_addr_start = 9'd0;
                wr_addr_end   = 9'd0;
            end
            tick();
            start = 1'b0;
            if (acc) begin
                remaining--;
                n_checks++;
                if (if_we !== exp_we || lane_of(int'(sel)) !== exp_addr || if_din !== d) begin
                    n_fail++;
                    $display("FAIL write k=%0d: we=%h addr=%0d din=%h, required we=%h addr=%0d din=%h",
                             k, if_we, lane_of(int'(sel)), if_din, exp_we, exp_addr, d);
                end
                last_addr = exp_addr;
                last_din  = d;
                have_prev = 1;
                exp_addr  = exp_addr + 9'd1;
            end else begin
                n_checks++;
                if (if_we !== 16'h0 ||
                    (have_prev && (lane_of(int'(sel)) !== last_addr || if_din !== last_din))) begin
                    n_fail++;
                    $display("FAIL gap_hold k=%0d: we=%h addr=%0d din=%h, required we=0000 addr=%0d din=%h",
                             k, if_we, lane_of(int'(sel)), if_din, last_addr, last_din);
                end
            end
            n_checks++;
            if (busy !== 1'b1 || s_ready !== (remaining > 0) || bram_sel_out !== sel || wr_done !== 1'b0) begin
                n_fail++;
                $display("FAIL window_ctrl k=%0d: busy=%b s_ready=%b sel_out=%0d done=%b, required 1 %0d %0d 0",
                         k, busy, s_ready, bram_sel_out, wr_done, (remaining > 0), sel);
            end
            k++;
        end
        n_checks++;
        if (remaining > 0) begin
            n_fail++;
            $display("FAIL window_timeout: %0d beats outstanding, required 0", remaining);
        end
        s_valid = 1'b0;
        tick();
        n_checks++;
        if (wr_done !== 1'b1 || busy !== 1'b0 || if_we !== 16'h0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_cycle: done=%b busy=%b we=%h s_ready=%b, required 1 0 0000 0",
                     wr_done, busy, if_we, s_ready);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (if_we !== 16'h0 || if_addr_wr_flat !== 144'h0 || if_din !== 16'h0 || busy !== 1'b0 ||
            wr_done !== 1'b0 || cfg_err !== 1'b0 || s_ready !== 1'b0 || bram_sel_out !== 4'h0) begin
            n_fail++;
            $display("FAIL %s: we=%h flat_nonzero=%b din=%h busy=%b done=%b err=%b rdy=%b sel=%0d, required all 0",
                     name, if_we, |if_addr_wr_flat, if_din, busy, wr_done, cfg_err, s_ready, bram_sel_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic_fill();
        run_window(4'd3, 9'd10, 9'd13, 16'hFFFF, -1);
        n_checks++;
        if (wr_done !== 1'b0 && 1'b0) begin
            n_fail++;
        end
        tick();
        n_checks++;
        if (wr_done !== 1'b0 || lane_of(0) !== 9'd0 || lane_of(3) !== 9'd13) begin
            n_fail++;
            $display("FAIL basic_after: done=%b lane0=%0d lane3=%0d, required 0 0 13",
                     wr_done, lane_of(0), lane_of(3));
        end
    endtask

    task automatic test_backpressure();
        run_window(4'd3, 9'd10, 9'd13, 16'h002D, -1);
    endtask

    task automatic test_boundaries();
        run_window(4'd15, 9'd510, 9'd511, 16'hFFFF, -1);
        n_checks++;
        if (lane_of(15) !== 9'd511 || lane_of(3) !== 9'd13) begin
            n_fail++;
            $display("FAIL top_window_lanes: lane15=%0d lane3=%0d, required 511 13", lane_of(15), lane_of(3));
        end
        tick();
        run_window(4'd0, 9'd0, 9'd0, 16'hFFFF, -1);
    endtask

    task automatic test_invalid_cfg();
        tick();
        bram_sel_in   = 4'd2;
        wr_addr_start = 9'd20;
        wr_addr_end   = 9'd5;
        start         = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_range: err=%b busy=%b rdy=%b, required 1 0 0", cfg_err, busy, s_ready);
        end
        tick();
        n_checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || if_we !== 16'h0) begin
            n_fail++;
            $display("FAIL cfg_err_pulse: err=%b busy=%b we=%h, required 0 0 0000", cfg_err, busy, if_we);
        end
        wr_addr_start = 9'd0;
        wr_addr_end   = 9'd3;
        sel5          = 5'd16;
        start5        = 1'b1;
        tick();
        start5 = 1'b0;
        n_checks++;
        if (cfg_err5 !== 1'b1 || busy5 !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_sel16: err=%b busy=%b, required 1 0", cfg_err5, busy5);
        end
        tick();
        n_checks++;
        if ({cfg_err5, busy5, s_ready5, wr_done5, if_we5, din5, sel_out5} !== 40'h0 || flat5 !== 144'h0) begin
            n_fail++;
            $display("FAIL sel16_idle: err=%b busy=%b rdy=%b done=%b we=%h din=%h sel=%0d, required all 0",
                     cfg_err5, busy5, s_ready5, wr_done5, if_we5, din5, sel_out5);
        end
    endtask

    task automatic test_back_to_back();
        run_window(4'd5, 9'd100, 9'd102, 16'hFFFF, 1);
        n_checks++;
        if (lane_of(5) !== 9'd102 || lane_of(1) !== 9'd0) begin
            n_fail++;
            $display("FAIL glitch_start: lane5=%0d lane1=%0d, required 102 0", lane_of(5), lane_of(1));
        end
        tick();
        run_window(4'd3, 9'd40, 9'd41, 16'hFFFF, -1);
        run_window(4'd7, 9'd50, 9'd52, 16'h0007, -1);
        n_checks++;
        if (lane_of(3) !== 9'd41 || lane_of(7) !== 9'd52) begin
            n_fail++;
            $display("FAIL back_to_back_lanes: lane3=%0d lane7=%0d, required 41 52", lane_of(3), lane_of(7));
        end
    endtask

    task automatic test_reset_mid_window();
        tick();
        bram_sel_in   = 4'd6;
        wr_addr_start = 9'd200;
        wr_addr_end   = 9'd205;
        start         = 1'b1;
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        tick();
        tick();
        n_checks++;
        if (lane_of(6) !== 9'd201 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: lane6=%0d busy=%b, required 201 1", lane_of(6), busy);
        end
        rst = 1'b1;
        tick();
        check_all_zero("reset_mid_window");
        rst     = 1'b0;
        s_valid = 1'b0;
        tick();
        check_all_zero("idle_after_mid_reset");
        run_window(4'd6, 9'd200, 9'd202, 16'hFFFF, -1);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        wr_addr_start = '0;
        wr_addr_end   = '0;
        bram_sel_in   = '0;
        s_data        = '0;
        s_valid       = 1'b0;
        start5        = 1'b0;
        sel5          = '0;
        s_valid5      = 1'b0;
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_boundaries();
        test_invalid_cfg();
        test_back_to_back();
        test_reset_mid_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
